alu_exec_ctrl: RTL and testbench

Operand-fetch, issue and writeback stage wrapped around the combinational ALU. Accepts 16-bit instruction words over a valid/ready handshake, reads two source registers from an internal 16×32 register file, and presents registered `r2`/`r3`/`opcode` to the ALU. One cycle later it captures the ALU's `r1` and `flags`, writes the result back, and updates a 4-bit status register. Includes result forwarding and a host load port for register initialisation.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_regfile.sv | 57 +++++
 rtl/alu_exec_ctrl.sv | 149 ++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcode encoding, instruction
// field positions and datapath defaults.
package alu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int NREGS_DEF = 16;
  localparam int REG_AW    = 4;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_OR  = 4'd3,
    OP_AND = 4'd4,
    OP_XOR = 4'd5,
    OP_LSL = 4'd6,
    OP_LSR = 4'd7,
    OP_ROR = 4'd8,
    OP_CMP = 4'd9,
    OP_NOP = 4'd15
  } opcode_e;

  // Opcodes the ALU executes directly and whose result goes to rd.
  function automatic logic is_alu_op(input logic [3:0] opc);
    return opc <= OP_ROR;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file with three combinational read ports; R0 is constant zero.
// Loads and writebacks arrive already arbitrated by the caller.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [WIDTH-1:0]  rs1_data,
  output logic [WIDTH-1:0]  rs2_data,
  output logic [WIDTH-1:0]  dbg_data
);

  logic [NREGS-1:0][WIDTH-1:0] rf;

  assign rf[0] = '0;

  for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] reg_d;

    always_comb begin
      reg_d = reg_q;
      if (ld_en && ld_addr == REG_AW'(gi)) begin
        reg_d = ld_data;
      end else if (wb_en && wb_addr == REG_AW'(gi)) begin
        reg_d = wb_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        reg_q <= '0;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign rf[gi] = reg_q;
  end

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];
  assign dbg_data = rf[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Issue/execute/writeback wrapper around a single-cycle combinational ALU,
// with EX->issue forwarding and a host register-load port.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  input  logic             ld_valid,
  input  logic [3:0]       ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_r1,
  input  logic [3:0]       alu_flags,
  output logic [3:0]       flags_q,
  output logic             retire_valid,
  output logic [3:0]       retire_rd,
  output logic [WIDTH-1:0] retire_data,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [3:0]       opc, rd, rs1, rs2;
  logic             accept, fwd_ok, wb_en;
  logic [WIDTH-1:0] rs1_data, rs2_data, op_a, op_b;

  logic             ex_valid_q, ex_valid_d;
  logic             ex_wr_q, ex_wr_d;
  logic             ex_cmpflag_q, ex_cmpflag_d;
  logic [3:0]       ex_rd_q, ex_rd_d;
  logic [3:0]       alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]       flags_d;
  logic             retire_valid_q, retire_valid_d;
  logic [3:0]       retire_rd_q, retire_rd_d;
  logic [WIDTH-1:0] retire_data_q, retire_data_d;

  assign opc = in_instr[OPC_MSB:OPC_LSB];
  assign rd  = in_instr[RD_MSB:RD_LSB];
  assign rs1 = in_instr[RS1_MSB:RS1_LSB];
  assign rs2 = in_instr[RS2_MSB:RS2_LSB];

  assign in_ready = !ld_valid;
  assign accept   = in_valid && in_ready;

  // The EX result is written at the same edge this issue samples, so bypass it.
  assign fwd_ok = ex_valid_q && ex_wr_q && (ex_rd_q != 4'd0);
  assign op_a   = (fwd_ok && rs1 == ex_rd_q) ? alu_r1 : rs1_data;
  assign op_b   = (fwd_ok && rs2 == ex_rd_q) ? alu_r1 : rs2_data;

  // A host load to the same register in the same cycle overrides the writeback.
  assign wb_en = fwd_ok && !(ld_valid && ld_addr == ex_rd_q);

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_en    (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .wb_en    (wb_en),
    .wb_addr  (ex_rd_q),
    .wb_data  (alu_r1),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .dbg_addr (dbg_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dbg_data (dbg_data)
  );

  always_comb begin
    ex_valid_d     = accept;
    ex_wr_d        = ex_wr_q;
    ex_cmpflag_d   = ex_cmpflag_q;
    ex_rd_d        = ex_rd_q;
    alu_opcode_d   = alu_opcode_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    if (accept) begin
      ex_wr_d      = is_alu_op(opc);
      ex_cmpflag_d = (opc == OP_CMP);
      ex_rd_d      = rd;
      alu_a_d      = op_a;
      alu_b_d      = op_b;
      if (is_alu_op(opc)) begin
        alu_opcode_d = opc;
      end else if (opc == OP_CMP) begin
        alu_opcode_d = OP_SUB;
      end else begin
        alu_opcode_d = OP_ADD;
      end
    end

    flags_d = flags_q;
    if (ex_valid_q && (ex_wr_q || ex_cmpflag_q)) begin
      flags_d = alu_flags;
    end

    retire_valid_d = ex_valid_q;
    retire_rd_d    = ex_valid_q ? ex_rd_q : retire_rd_q;
    retire_data_d  = ex_valid_q ? alu_r1  : retire_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_wr_q        <= 1'b0;
      ex_cmpflag_q   <= 1'b0;
      ex_rd_q        <= '0;
      alu_opcode_q   <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      flags_q        <= '0;
      retire_valid_q <= 1'b0;
      retire_rd_q    <= '0;
      retire_data_q  <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_wr_q        <= ex_wr_d;
      ex_cmpflag_q   <= ex_cmpflag_d;
      ex_rd_q        <= ex_rd_d;
      alu_opcode_q   <= alu_opcode_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      flags_q        <= flags_d;
      retire_valid_q <= retire_valid_d;
      retire_rd_q    <= retire_rd_d;
      retire_data_q  <= retire_data_d;
    end
  end

  assign alu_opcode   = alu_opcode_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign retire_valid = retire_valid_q;
  assign retire_rd    = retire_rd_q;
  assign retire_data  = retire_data_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: a behavioural ALU drives alu_r1/alu_flags, and an
// in-order architectural register model predicts retires, flags and reads.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic        ld_valid = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_a, alu_b, alu_r1;
  logic [3:0]  alu_flags;
  logic [3:0]  flags_q;
  logic        retire_valid;
  logic [3:0]  retire_rd;
  logic [31:0] retire_data;
  logic [3:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_r1       (alu_r1),
    .alu_flags    (alu_flags),
    .flags_q      (flags_q),
    .retire_valid (retire_valid),
    .retire_rd    (retire_rd),
    .retire_data  (retire_data),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // ALU behaviour: returns {N,Z,C,V, result}.
  function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] wide;
    logic [31:0] r;
    logic        c, v;
    wide = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[31:0]; c = wide[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd1: begin
        r = a - b; c = (a >= b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd2: r = a * b;
      4'd3: r = a | b;
      4'd4: r = a & b;
      4'd5: r = a ^ b;
      4'd6: r = a << b[4:0];
      4'd7: r = a >> b[4:0];
      4'd8: r = (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}));
      default: r = '0;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  always_comb {alu_flags, alu_r1} = alu_fn(alu_opcode, alu_a, alu_b);

  // Architectural model: instructions take effect in accept order.
  logic [31:0] mreg [16];
  logic [3:0]  mflags;
  logic        pend_v, pend_wr, pend_flg, pend_chk;
  logic [3:0]  pend_rd, pend_flags;
  logic [31:0] pend_data;
  logic        ret_v, ret_chk;
  logic [3:0]  ret_rd;
  logic [31:0] ret_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = '0;
    mflags = '0;
    pend_v = 1'b0; pend_wr = 1'b0; pend_flg = 1'b0; pend_chk = 1'b0;
    pend_rd = '0; pend_flags = '0; pend_data = '0;
    ret_v = 1'b0; ret_chk = 1'b0; ret_rd = '0; ret_data = '0;
  endtask

  task automatic model_edge();
    logic [3:0]  op;
    logic [35:0] res;
    ret_v = pend_v; ret_rd = pend_rd; ret_chk = pend_chk; ret_data = pend_data;
    if (pend_v) begin
      if (pend_wr && pend_rd != 4'd0) mreg[pend_rd] = pend_data;
      if (pend_flg) mflags = pend_flags;
    end
    if (ld_valid && ld_addr != 4'd0) mreg[ld_addr] = ld_data;
    pend_v  = in_valid && !ld_valid;
    op      = in_instr[15:12];
    pend_rd = in_instr[11:8];
    res     = '0;
    if (op <= 4'd8) begin
      res = alu_fn(op, mreg[in_instr[7:4]], mreg[in_instr[3:0]]);
      pend_wr = 1'b1; pend_flg = 1'b1; pend_chk = 1'b1;
    end else if (op == 4'd9) begin
      res = alu_fn(4'd1, mreg[in_instr[7:4]], mreg[in_instr[3:0]]);
      pend_wr = 1'b0; pend_flg = 1'b1; pend_chk = 1'b1;
    end else begin
      pend_wr = 1'b0; pend_flg = 1'b0; pend_chk = 1'b0;
    end
    pend_data  = res[31:0];
    pend_flags = res[35:32];
  endtask

  task automatic check_cycle();
    chk("retire_valid", {31'd0, retire_valid}, {31'd0, ret_v});
    if (ret_v) chk("retire_rd", {28'd0, retire_rd}, {28'd0, ret_rd});
    if (ret_v && ret_chk) chk("retire_data", retire_data, ret_data);
    chk("flags_q", {28'd0, flags_q}, {28'd0, mflags});
    chk($sformatf("dbg_r%0d", dbg_addr), dbg_data, mreg[dbg_addr]);
    chk("in_ready", {31'd0, in_ready}, {31'd0, !ld_valid});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    else begin
      ret_v = 1'b0; pend_v = 1'b0;
    end
    @(negedge clk);
    check_cycle();
  endtask

  task automatic drive(input logic iv, input logic [15:0] ins, input logic lv,
                       input logic [3:0] la, input logic [31:0] ldat, input logic [3:0] da);
    in_valid = iv; in_instr = ins; ld_valid = lv; ld_addr = la; ld_data = ldat; dbg_addr = da;
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [31:0] exp;
    logic        chk_ret;
  } vec_t;
  vec_t vecs [10];

  initial begin
    // R1=5, R2=7 for every vector; rd values chosen to avoid R1..R7.
    vecs[0] = '{16'h0812, 32'd12,         1'b1};
    vecs[1] = '{16'h1912, 32'hFFFF_FFFE,  1'b1};
    vecs[2] = '{16'h2A12, 32'd35,         1'b1};
    vecs[3] = '{16'h3B12, 32'd7,          1'b1};
    vecs[4] = '{16'h4C12, 32'd5,          1'b1};
    vecs[5] = '{16'h5D12, 32'd2,          1'b1};
    vecs[6] = '{16'h6E12, 32'd640,        1'b1};
    vecs[7] = '{16'h7F12, 32'd0,          1'b1};
    vecs[8] = '{16'h8812, 32'h0A00_0000,  1'b1};
    vecs[9] = '{16'hC912, 32'hFFFF_FFFE,  1'b0};

    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("reset_retire", {31'd0, retire_valid}, 32'd0);
    chk("reset_alu_a", alu_a, 32'd0);
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      drive(0, 0, 0, 0, 0, 4'(a));
      tick();
    end
    chk("reset_flags", {28'd0, flags_q}, 32'd0);

    drive(0, 0, 1, 4'd1, 32'd5, 4'd1); tick();
    chk("load_r1", dbg_data, 32'd5);
    drive(0, 0, 1, 4'd2, 32'd7, 4'd2); tick();
    chk("load_r2", dbg_data, 32'd7);

    drive(1, 16'h0312, 0, 0, 0, 4'd3); tick();
    chk("add_alu_opcode", {28'd0, alu_opcode}, 32'd0);
    chk("add_alu_a", alu_a, 32'd5);
    chk("add_alu_b", alu_b, 32'd7);
    drive(0, 0, 0, 0, 0, 4'd3); tick();
    chk("add_retire_rd", {28'd0, retire_rd}, 32'd3);
    chk("add_retire_data", retire_data, 32'd12);
    chk("add_r3", dbg_data, 32'd12);

    for (int i = 0; i < 10; i++) begin
      drive(1, vecs[i].instr, 0, 0, 0, vecs[i].instr[11:8]); tick();
      drive(0, 0, 0, 0, 0, vecs[i].instr[11:8]); tick();
      chk($sformatf("vec%0d_retire", i), {31'd0, retire_valid}, 32'd1);
      if (vecs[i].chk_ret) chk($sformatf("vec%0d_data", i), retire_data, vecs[i].exp);
      chk($sformatf("vec%0d_reg", i), dbg_data, vecs[i].exp);
    end

    drive(1, 16'h0311, 0, 0, 0, 4'd3); tick();
    drive(1, 16'h0433, 0, 0, 0, 4'd4); tick();
    chk("fwd_alu_a", alu_a, 32'd10);
    chk("fwd_alu_b", alu_b, 32'd10);
    drive(0, 0, 0, 0, 0, 4'd4); tick();
    chk("fwd_retire_data", retire_data, 32'd20);
    chk("fwd_r4", dbg_data, 32'd20);

    drive(1, 16'h9611, 0, 0, 0, 4'd6); tick();
    chk("cmp_alu_opcode", {28'd0, alu_opcode}, 32'd1);
    drive(1, 16'hF000, 0, 0, 0, 4'd6); tick();
    chk("cmp_flags", {28'd0, flags_q}, 32'b0110);
    chk("cmp_r6", dbg_data, 32'd0);
    drive(0, 0, 0, 0, 0, 4'd6); tick();
    chk("nop_retire", {31'd0, retire_valid}, 32'd1);
    chk("nop_flags", {28'd0, flags_q}, 32'b0110);
    tick();
    chk("nop_single_pulse", {31'd0, retire_valid}, 32'd0);

    drive(1, 16'h0512, 0, 0, 0, 4'd5); tick();
    drive(1, 16'h0712, 1, 4'd5, 32'hDEAD_BEEF, 4'd5); tick();
    chk("collide_in_ready", {31'd0, in_ready}, 32'd0);
    chk("collide_r5", dbg_data, 32'hDEAD_BEEF);
    drive(0, 0, 0, 0, 0, 4'd7); tick();
    chk("blocked_no_retire", {31'd0, retire_valid}, 32'd0);

    drive(1, 16'h0012, 0, 0, 0, 4'd0); tick();
    drive(0, 0, 0, 0, 0, 4'd0); tick();
    chk("r0_retire", {31'd0, retire_valid}, 32'd1);
    chk("r0_zero", dbg_data, 32'd0);

    drive(1, 16'h0712, 0, 0, 0, 4'd7); tick();
    drive(0, 0, 0, 0, 0, 4'd7);
    rst_n = 1'b0;
    model_reset();
    #2 rst_n = 1'b1;
    tick();
    chk("midreset_no_retire", {31'd0, retire_valid}, 32'd0);
    chk("midreset_r7", dbg_data, 32'd0);

    for (int c = 0; c < 400; c++) begin
      int r;
      r = $urandom_range(0, 7);
      drive(r >= 1,
            {4'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
            r < 2, 4'($urandom_range(0, 4)), $urandom, 4'($urandom));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
